// File: rtl/hdmi_stream_arbiter_if.sv
// Pixel stream bundle: data/valid/ready plus sof/eol framing.
// master drives the beat, slave returns ready.
interface hdmi_stream_arbiter_if #(
  parameter int DW = 24
) ();
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          sof;
  logic          eol;

  modport master (
    output data, valid, sof, eol,
    input  ready
  );

  modport slave (
    input  data, valid, sof, eol,
    output ready
  );
endinterface

// File: rtl/hdmi_stream_arbiter.sv
// Frame-granular two-source arbiter in front of the HDMI wrapper.
// Grants one full frame at a time and checks frame geometry.
module hdmi_stream_arbiter #(
  parameter int DW       = 24,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int TIMEOUT  = 1024
) (
  input  logic                 i_clk_pixel,
  input  logic                 i_rstn,
  hdmi_stream_arbiter_if.slave  s0,
  hdmi_stream_arbiter_if.slave  s1,
  hdmi_stream_arbiter_if.master sink,
  output logic                 o_owner,
  output logic                 o_busy,
  output logic [15:0]          o_frame_cnt,
  output logic [2:0]           o_err,
  input  logic                 i_err_clr
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int SW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic          owner;
  logic          last_owner;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [SW-1:0] stall;
  logic [15:0]   frame_cnt;
  logic [2:0]    err;

  logic          req0, req1, pick;
  logic          grant;
  logic          own_valid, own_sof, own_eol;
  logic [DW-1:0] own_data;
  logic          acc, restart, line_end;
  logic          frame_end, tmo;
  logic [2:0]    err_set;

  assign req0  = s0.valid & s0.sof;
  assign req1  = s1.valid & s1.sof;
  assign pick  = (req0 & req1) ? ~last_owner : req1;
  assign grant = (state == GRANT);

  assign own_valid = owner ? s1.valid : s0.valid;
  assign own_sof   = owner ? s1.sof   : s0.sof;
  assign own_eol   = owner ? s1.eol   : s0.eol;
  assign own_data  = owner ? s1.data  : s0.data;

  always_comb begin
    sink.valid = 1'b0;
    sink.sof   = 1'b0;
    sink.eol   = 1'b0;
    sink.data  = '0;
    s0.ready   = 1'b0;
    s1.ready   = 1'b0;
    if (i_rstn) begin
      unique case (state)
        IDLE: begin
          s0.ready = s0.valid & ~s0.sof;
          s1.ready = s1.valid & ~s1.sof;
        end
        GRANT: begin
          sink.valid = own_valid;
          sink.sof   = own_sof;
          sink.eol   = own_eol;
          sink.data  = own_data;
          s0.ready   = ~owner & sink.ready;
          s1.ready   = owner & sink.ready;
        end
        default: ;
      endcase
    end
  end

  assign acc       = grant & own_valid & sink.ready;
  assign restart   = acc & own_sof & ((x != '0) | (y != '0));
  assign line_end  = acc & own_eol & ~restart;
  assign frame_end = line_end & (y == YW'(V_ACTIVE - 1));
  assign tmo       = grant & ~own_valid & (stall == SW'(TIMEOUT - 1));

  assign err_set = {tmo, restart,
                    line_end & (x != XW'(H_ACTIVE - 1))};

  always_ff @(posedge i_clk_pixel) begin
    if (!i_rstn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      x          <= '0;
      y          <= '0;
      stall      <= '0;
      frame_cnt  <= '0;
      err        <= '0;
    end else begin
      err <= (i_err_clr ? 3'b000 : err) | err_set;
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            state <= GRANT;
            owner <= pick;
            x     <= '0;
            y     <= '0;
            stall <= '0;
          end
        end
        GRANT: begin
          if (!own_valid) begin
            if (tmo) begin
              state      <= IDLE;
              last_owner <= owner;
            end else begin
              stall <= stall + SW'(1);
            end
          end else begin
            stall <= '0;
          end
          // a stray sof restarts the frame at its own pixel
          if (restart) begin
            x <= own_eol ? XW'(0) : XW'(1);
            y <= '0;
          end else if (line_end) begin
            x <= '0;
            if (frame_end) begin
              frame_cnt  <= frame_cnt + 16'd1;
              last_owner <= owner;
              state      <= IDLE;
            end else begin
              y <= y + YW'(1);
            end
          end else if (acc) begin
            x <= x + XW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_owner     = owner;
  assign o_busy      = grant;
  assign o_frame_cnt = frame_cnt;
  assign o_err       = err;

endmodule

// File: tb/tb_hdmi_stream_arbiter.sv
// Directed bench for hdmi_stream_arbiter with a 4x2 frame.
// Expected values are hand-derived per step.
module tb_hdmi_stream_arbiter;
  localparam int DW = 24;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clr = 1'b0;
  logic        owner, busy;
  logic [15:0] fcnt;
  logic [2:0]  err;
  int          checks = 0;
  int          errors = 0;
  int          b;

  hdmi_stream_arbiter_if #(.DW(DW)) s0 ();
  hdmi_stream_arbiter_if #(.DW(DW)) s1 ();
  hdmi_stream_arbiter_if #(.DW(DW)) snk ();

  hdmi_stream_arbiter #(
    .DW(DW), .H_ACTIVE(4), .V_ACTIVE(2), .TIMEOUT(8)
  ) dut (
    .i_clk_pixel(clk),
    .i_rstn(rstn),
    .s0(s0),
    .s1(s1),
    .sink(snk),
    .o_owner(owner),
    .o_busy(busy),
    .o_frame_cnt(fcnt),
    .o_err(err),
    .i_err_clr(clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit src, input bit v, input logic [DW-1:0] d,
                       input bit sof, input bit eol);
    if (src) begin
      s1.valid = v; s1.data = d; s1.sof = sof; s1.eol = eol;
    end else begin
      s0.valid = v; s0.data = d; s0.sof = sof; s0.eol = eol;
    end
  endtask

  task automatic xfer(input bit src, input logic [DW-1:0] d,
                      input bit sof, input bit eol);
    bit   done = 1'b0;
    logic rdy;
    drive(src, 1'b1, d, sof, eol);
    for (int i = 0; i < 16 && !done; i++) begin
      #1;
      rdy = src ? s1.ready : s0.ready;
      if (rdy && snk.valid && snk.ready) begin
        chk("xfer_beat", 32'({snk.sof, snk.eol, snk.data}),
            32'({sof, eol, d}));
        done = 1'b1;
      end
      tick();
    end
    chk("xfer_done", 32'(done), 1);
    drive(src, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input bit src, input logic [DW-1:0] base);
    for (int i = 0; i < 8; i++)
      xfer(src, base + DW'(i), i == 0, i == 3 || i == 7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, 1'b0, 1'b0);
    snk.ready = 1'b1;
    // reset state, with s0 presenting a non-sof beat
    drive(0, 1'b1, 24'h111, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_valid", 32'(snk.valid), 0);
    chk("rst_data", 32'(snk.data), 0);
    chk("rst_ready0", 32'(s0.ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fcnt", 32'(fcnt), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_owner", 32'(owner), 0);
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    rstn = 1'b1;
    tick();

    // single-source frame
    for (int i = 0; i < 7; i++)
      xfer(0, 24'h100 + DW'(i), i == 0, i == 3);
    drive(0, 1'b1, 24'h107, 1'b0, 1'b1);
    #1;
    chk("t1_last_valid", 32'(snk.valid), 1);
    chk("t1_fcnt_pre", 32'(fcnt), 0);
    tick();
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    chk("t1_fcnt", 32'(fcnt), 1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_err", 32'(err), 0);
    chk("t1_owner", 32'(owner), 0);

    // tie after reset: s0 first, then alternate
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    drive(0, 1'b1, 24'h2aa, 1'b1, 1'b0);
    drive(1, 1'b1, 24'h3bb, 1'b1, 1'b0);
    #1;
    chk("t2_req_rdy0", 32'(s0.ready), 0);
    chk("t2_req_rdy1", 32'(s1.ready), 0);
    chk("t2_idle_valid", 32'(snk.valid), 0);
    tick();
    chk("t2_owner0", 32'(owner), 0);
    chk("t2_busy", 32'(busy), 1);
    chk("t2_hold1", 32'(s1.ready), 0);
    send_frame(0, 24'h200);
    chk("t2_idle", 32'(busy), 0);
    chk("t2_fcnt1", 32'(fcnt), 1);
    chk("t2_hold1_idle", 32'(s1.ready), 0);
    send_frame(1, 24'h300);
    chk("t2_owner1", 32'(owner), 1);
    chk("t2_fcnt2", 32'(fcnt), 2);
    drive(0, 1'b1, 24'h4aa, 1'b1, 1'b0);
    drive(1, 1'b1, 24'h4bb, 1'b1, 1'b0);
    send_frame(0, 24'h400);
    drive(1, 1'b0, '0, 1'b0, 1'b0);
    chk("t2_owner2", 32'(owner), 0);
    chk("t2_fcnt3", 32'(fcnt), 3);

    // drain of mid-frame beats while idle
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b1, 24'h500 + DW'(i), 1'b0, 1'b0);
      #1;
      chk("t3_drain_rdy", 32'(s1.ready), 1);
      chk("t3_drain_valid", 32'(snk.valid), 0);
      tick();
    end
    send_frame(1, 24'h600);
    chk("t3_owner", 32'(owner), 1);
    chk("t3_fcnt", 32'(fcnt), 4);
    chk("t3_busy", 32'(busy), 0);

    // backpressure never times out, valid-low stall does
    xfer(0, 24'h700, 1'b1, 1'b0);
    b = 1;
    for (int k = 0; k < 20; k++) begin
      drive(0, 1'b1, 24'h700 + DW'(b), 1'b0, b == 3);
      snk.ready = (k < 10) && k[0];
      #1;
      if (snk.ready) begin
        chk("t4_bp_beat", 32'(snk.data), 32'h700 + 32'(b));
        b++;
      end
      tick();
    end
    chk("t4_bp_count", 32'(b), 6);
    chk("t4_bp_busy", 32'(busy), 1);
    chk("t4_bp_err", 32'(err), 0);
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    snk.ready = 1'b1;
    repeat (7) tick();
    chk("t4_stall7_busy", 32'(busy), 1);
    chk("t4_stall7_err", 32'(err), 0);
    tick();
    chk("t4_tmo_busy", 32'(busy), 0);
    chk("t4_tmo_err", 32'(err), 4);
    chk("t4_tmo_fcnt", 32'(fcnt), 4);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t4_clr", 32'(err), 0);

    // short line, then stray sof restarting the frame
    xfer(0, 24'h800, 1'b1, 1'b0);
    xfer(0, 24'h801, 1'b0, 1'b0);
    xfer(0, 24'h802, 1'b0, 1'b1);
    chk("t5_len_err", 32'(err), 1);
    xfer(0, 24'h803, 1'b0, 1'b0);
    xfer(0, 24'h804, 1'b0, 1'b0);
    xfer(0, 24'h805, 1'b1, 1'b0);
    chk("t5_sof_err", 32'(err), 3);
    chk("t5_sof_busy", 32'(busy), 1);
    xfer(0, 24'h806, 1'b0, 1'b0);
    xfer(0, 24'h807, 1'b0, 1'b0);
    xfer(0, 24'h808, 1'b0, 1'b1);
    xfer(0, 24'h809, 1'b0, 1'b0);
    xfer(0, 24'h80a, 1'b0, 1'b0);
    xfer(0, 24'h80b, 1'b0, 1'b0);
    xfer(0, 24'h80c, 1'b0, 1'b1);
    chk("t5_fcnt", 32'(fcnt), 5);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_err_sticky", 32'(err), 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_clr", 32'(err), 0);

    // reset mid-frame
    xfer(0, 24'h900, 1'b1, 1'b0);
    xfer(0, 24'h901, 1'b0, 1'b1);
    chk("t6_err_pre", 32'(err), 1);
    drive(0, 1'b1, 24'h902, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(snk.valid), 0);
    chk("t6_rst_ready", 32'(s0.ready), 0);
    tick();
    chk("t6_busy", 32'(busy), 0);
    chk("t6_fcnt", 32'(fcnt), 0);
    chk("t6_err", 32'(err), 0);
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    rstn = 1'b1;
    tick();
    chk("t6_owner", 32'(owner), 0);
    chk("t6_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hdmi_stream_arbiter.md
# hdmi_stream_arbiter

Frame-granular arbiter that shares the single pixel-stream input of the HDMI wrapper (data/valid/ready/sof/eol) between two pixel sources, e.g. a test-pattern generator and a framebuffer reader. It grants the sink to one source for exactly one complete frame, discards mid-frame data from idle sources until they realign on start-of-frame, and checks frame geometry. It sits in the pixel clock domain directly in front of the HDMI wrapper.

## Interface
- DW, 24, pixel data width (RGB888)
- H_ACTIVE, 640, pixels per line (beats from sof/line start to eol inclusive)
- V_ACTIVE, 480, lines per frame
- TIMEOUT, 1024, max consecutive cycles the granted source may hold valid low mid-frame
- i_clk_pixel  in  1  pixel clock; single clock domain
- i_rstn  in  1  synchronous, active-low reset
- i_s0_data / i_s1_data  in  DW  source pixel data
- i_s0_valid / i_s1_valid  in  1  source beat valid
- o_s0_ready / o_s1_ready  out  1  source beat accepted when valid&ready
- i_s0_sof / i_s1_sof  in  1  first pixel of frame
- i_s0_eol / i_s1_eol  in  1  last pixel of line
- o_data  out  DW  to wrapper i_data
- o_valid, o_sof, o_eol  out  1  to wrapper i_valid, i_sof, i_eol
- i_ready  in  1  from wrapper o_ready
- o_owner  out  1  current/last granted source
- o_busy  out  1  high in GRANT
- o_frame_cnt  out  16  completed frames, wraps 0xFFFF->0
- o_err  out  3  sticky: [0] line length, [1] unexpected sof, [2] timeout
- i_err_clr  in  1  clears o_err

## Operation
- States: IDLE, GRANT. Registers: owner, last_owner, x (pixel count), y (line count), stall counter, frame_cnt, err.
- IDLE: o_valid=0. Per source: valid&!sof -> ready=1, beat discarded (drain); valid&sof -> request, ready=0 (sof beat held). One requester -> grant it; both -> grant the source != last_owner. Next state GRANT, x=y=0, stall=0.
- GRANT: o_data/o_valid/o_sof/o_eol = owner's inputs; owner ready = i_ready; non-owner ready=0 (held, not drained).
- Accepted beat (o_valid&i_ready): x++. Accepted eol: if x != H_ACTIVE-1 set err[0]; x=0; if y==V_ACTIVE-1 -> frame done, else y++.
- Accepted sof when x!=0 or y!=0: set err[1]; treat as new frame: x=1 (or 0 if also eol), y=0; stay GRANT.
- Frame done: frame_cnt++, last_owner=owner, -> IDLE.
- Stall: in GRANT, owner valid=0 increments stall; valid=1 clears it. i_ready=0 with valid=1 is sink backpressure and never counts. stall reaching TIMEOUT: set err[2], last_owner=owner, -> IDLE, frame_cnt unchanged.
- err bits set and clear in same cycle: set wins. Clear is all bits.
- Widths: x sized clog2(H_ACTIVE), y clog2(V_ACTIVE), stall clog2(TIMEOUT+1); no counter wraps within a legal frame.

## Timing
- Reset (i_rstn=0 at edge): state IDLE, owner=0, last_owner=1 (s0 wins first tie), x=y=stall=0, o_frame_cnt=0, o_err=0, o_busy=0. Combinational outputs under reset: o_valid=0, o_sof=0, o_eol=0, o_data=0, both source readies 0.
- Reset mid-frame: aborts frame at next edge, no counter increment, no error.
- Datapath in GRANT is zero-latency combinational pass-through; no buffering.
- Grant latency: sof request visible in IDLE at cycle n -> GRANT at n+1; sof beat may transfer at n+1.
- Final eol accepted at cycle m -> IDLE at m+1, o_frame_cnt updated at m+1; earliest next sof transfer m+2.
- Drained beats in IDLE are accepted in the same cycle they are presented.
- o_busy, o_owner registered (reflect state after edge).

## Test plan (H_ACTIVE=4, V_ACTIVE=2, TIMEOUT=8)
- s0 only, 8-beat frame, sof on beat 0, eol on 3 and 7, i_ready=1 -> 8 beats on output, o_frame_cnt 0->1 one cycle after last eol, o_err=0, owner=0.
- Both assert sof in same IDLE cycle after reset -> s0 granted first; s1 held (ready=0) whole frame, then granted in next IDLE; a third pair of frames alternates s0.
- s1 presents 3 non-sof beats then sof while idle -> 3 beats drained (ready=1, o_valid=0), sof starts s1 frame.
- i_ready toggles 1/0 during frame with owner valid=1 for 20 cycles -> no timeout, data order preserved; owner valid=0 for 8 cycles mid-frame -> err[2]=1, IDLE, o_frame_cnt unchanged.
- eol on beat 2 of line 0 -> err[0]=1; sof on beat 5 -> err[1]=1, frame restarts; i_err_clr pulse -> o_err=0 next cycle.
- i_rstn=0 for one cycle mid-frame -> IDLE, counters and o_err cleared, o_valid=0 during reset cycle.
